// File: rtl/rv32_id_stage_if.sv
// Handshake and decoded-field bundle between IF/ID, the decode stage and ID/EX.
// master = environment driving the stage; slave = the decode stage itself.
interface rv32_id_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/rv32_id_stage.sv
// RV32 instruction decode stage: combinational field/immediate decode into a
// 2-entry skid buffer (main + skid); 1-cycle latency, in_ready/out_valid registered.
module rv32_id_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  rv32_id_stage_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  state_e      state_q;
  dec_t        main_q;
  dec_t        skid_q;
  dec_t        dec_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] instr;
  logic signed [31:0] imm32;
  logic        accept;
  logic        transfer;

  assign instr = bus.in_instr;

  always_comb begin
    imm32        = '0;
    dec_d        = '0;
    dec_d.pc     = bus.in_pc;
    dec_d.opcode = instr[6:0];
    dec_d.rd     = instr[11:7];
    dec_d.funct3 = instr[14:12];
    dec_d.rs1    = instr[19:15];
    dec_d.rs2    = instr[24:20];
    dec_d.funct7 = instr[31:25];
    // Every legal opcode ends in 2'b11, so non-32-bit encodings fall to default.
    case (instr[6:0])
      7'b0110011: dec_d.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_d.fmt = FMT_I;
        imm32     = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        dec_d.fmt = FMT_S;
        imm32     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec_d.fmt = FMT_B;
        imm32     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_d.fmt = FMT_U;
        imm32     = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_d.fmt = FMT_J;
        imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: dec_d.illegal = 1'b1;
    endcase
    // imm32 is already sign-extended to bit 31; the signed cast carries it to XLEN.
    dec_d.imm = XLEN'(imm32);
  end

  assign accept   = bus.in_valid & in_ready_q & ~bus.flush;
  assign transfer = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            main_q      <= dec_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (transfer && accept) begin
            main_q <= dec_d;
          end else if (transfer) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            skid_q     <= dec_d;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end
        end
        FULL: begin
          if (transfer) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_funct7  = main_q.funct7;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;

endmodule
